rotary_settings_controller: RTL and testbench
=============================================

ROTARY_SETTINGS_CONTROLLER -- requirements
Module: rotary_settings_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable-high cycles before a push is accepted (min 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000000: idle cycles before the selection returns to volume (min 2).
REQ-003 SHALL have port clk, input, 1: single system clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port rotary_inc_a, input, 1: raw quadrature channel A, asynchronous.
REQ-006 SHALL have port rotary_inc_b, input, 1: raw quadrature channel B, asynchronous.
REQ-007 SHALL have port rotary_push, input, 1: raw encoder push button, asynchronous, active-high, bouncy.
REQ-008 SHALL have port volume, output, 4: volume level setting.
REQ-009 SHALL have port brightness, output, 4: brightness level setting.
REQ-010 SHALL have port contrast, output, 4: contrast level setting.
REQ-011 SHALL have port sel, output, 2: setting currently edited; 0=volume, 1=brightness, 2=contrast, 3 unused.
REQ-012 SHALL have port step_pulse, output, 1: one-cycle strobe for each accepted detent.
REQ-013 SHALL have port step_up, output, 1: direction of the last detent; 1=increment; valid while step_pulse=1.

Function
REQ-014 SHALL pass rotary_inc_a, rotary_inc_b and rotary_push each through a 2-flop synchronizer before any use.
REQ-015 SHALL decode synchronized A/B with a 7-state FSM: IDLE, A1, AB_A, B_A, B1, AB_B, A_B.
REQ-016 From IDLE: A=1 -> A1; else B=1 -> B1; else stay.
REQ-017 A-first path: A1 -(A&B)-> AB_A -(B&~A)-> B_A; any state on the path returns to the previous path state on a reverse transition.
REQ-018 A-first path detent: AB_A or B_A reaching A=0,B=0 -> IDLE, issuing one decrement detent; A1 reaching 00 -> IDLE with no detent.
REQ-019 B-first path: mirror of REQ-017/018 (B1, AB_B, A_B), issuing one increment detent; B1 reaching 00 -> IDLE with no detent.
REQ-020 An unreachable FSM encoding SHALL go to IDLE with no detent.
REQ-021 A detent SHALL update the setting selected by sel on the cycle the FSM enters IDLE, i.e. the level register changes one clock after the synchronized 00 is sampled.
REQ-022 step_pulse SHALL be high for exactly that cycle, with step_up valid.
REQ-023 At most one level SHALL change per detent; unselected levels SHALL hold.
REQ-024 rotary_push SHALL register a press only after the synchronized input has been high for DEBOUNCE_CYCLES consecutive cycles; any low sample restarts the count.
REQ-025 A press SHALL occur once per debounced rising level; a held button SHALL NOT repeat.
REQ-026 Each press SHALL advance sel 0->1->2->0.
REQ-027 On a detent and a press in the same cycle, the detent SHALL apply to the old sel; sel SHALL advance in the same edge.
REQ-028 An idle counter SHALL clear on every detent or press.
REQ-029 When the idle counter reaches TIMEOUT_CYCLES, sel SHALL return to 0 and the counter SHALL hold until the next activity.
REQ-030 Overflow behaviour at 4'hF and 4'h0 SHALL be as given in the Configuration section.

Reset
REQ-031 With reset=1 at a clk edge, the block SHALL set: volume=4'hE, brightness=4'h8, contrast=4'h8, sel=0, step_pulse=0, step_up=0, FSM=IDLE.
REQ-032 The same reset SHALL clear the synchronizers, the debounce counter and the idle counter.
REQ-033 Reset mid-rotation or mid-debounce SHALL discard the partial sequence; no detent or press SHALL be issued from pre-reset state.

Configuration
REQ-034 Macro LEVEL_WRAP_EN SHALL select overflow behaviour.
REQ-035 With LEVEL_WRAP_EN defined: increment at 4'hF gives 4'h0; decrement at 4'h0 gives 4'hF.
REQ-036 Without LEVEL_WRAP_EN: a level saturates at 4'hF and 4'h0; step_pulse still fires when a level saturates.

Verification
REQ-037 After reset, B-first sequence 00,01,11,10,00 with each step held 4 cycles -> brightness/contrast unchanged, volume 4'hE->4'hF, exactly one step_pulse with step_up=1.
REQ-038 Push held 20 cycles with DEBOUNCE_CYCLES=16 -> sel 0->1 once; then A-first detent -> brightness 4'h8->4'h7, step_up=0.
REQ-039 Push toggling every 5 cycles for 100 cycles, then low -> sel unchanged.
REQ-040 Volume at 4'hF plus one B-first detent -> 4'hF without LEVEL_WRAP_EN, 4'h0 with LEVEL_WRAP_EN; step_pulse fires in both builds.
REQ-041 Partial rotation 00,10,00 -> no step_pulse. Reset asserted in state AB_A -> FSM IDLE, volume=4'hE.
REQ-042 TIMEOUT_CYCLES=100, sel=2, no activity for 100 cycles -> sel=0; a detent and a press in the same cycle from sel=1 -> brightness changes and sel=2.

Source files
------------

// File: rtl/rotary_settings_controller.sv
// Rotary encoder front end: quadrature detent decoder plus debounced push button,
// editing three 4-bit settings. Define LEVEL_WRAP_EN to wrap levels instead of saturating.
module rotary_settings_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rotary_inc_a,
    input  logic       rotary_inc_b,
    input  logic       rotary_push,
    output logic [3:0] volume,
    output logic [3:0] brightness,
    output logic [3:0] contrast,
    output logic [1:0] sel,
    output logic       step_pulse,
    output logic       step_up
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_DONE  = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_DONE = IDLE_W'(TIMEOUT_CYCLES);

    localparam logic [3:0] VOLUME_RST     = 4'hE;
    localparam logic [3:0] BRIGHTNESS_RST = 4'h8;
    localparam logic [3:0] CONTRAST_RST   = 4'h8;

    localparam logic [1:0] SEL_VOLUME     = 2'd0;
    localparam logic [1:0] SEL_BRIGHTNESS = 2'd1;
    localparam logic [1:0] SEL_CONTRAST   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_A1   = 3'd1,
        ST_AB_A = 3'd2,
        ST_B_A  = 3'd3,
        ST_B1   = 3'd4,
        ST_AB_B = 3'd5,
        ST_A_B  = 3'd6
    } state_e;

    // Bit order in the synchronizer: {push, a, b}.
    logic [2:0]        sync1_d, sync1_q;
    logic [2:0]        sync2_d, sync2_q;
    state_e            state_d, state_q;
    logic [DEB_W-1:0]  deb_cnt_d, deb_cnt_q;
    logic [IDLE_W-1:0] idle_cnt_d, idle_cnt_q;
    logic [3:0]        volume_d, volume_q;
    logic [3:0]        brightness_d, brightness_q;
    logic [3:0]        contrast_d, contrast_q;
    logic [1:0]        sel_d, sel_q;
    logic              step_pulse_d, step_pulse_q;
    logic              step_up_d, step_up_q;

    logic [1:0] ab;
    logic       push_s;
    logic       detent;
    logic       detent_up;
    logic       press;
    logic       activity;

    function automatic logic [3:0] step_level(input logic [3:0] lvl, input logic up);
`ifdef LEVEL_WRAP_EN
        step_level = up ? lvl + 4'd1 : lvl - 4'd1;
`else
        if (up) begin
            step_level = (lvl == 4'hF) ? lvl : lvl + 4'd1;
        end else begin
            step_level = (lvl == 4'h0) ? lvl : lvl - 4'd1;
        end
`endif
    endfunction

    always_comb begin
        sync1_d = {rotary_push, rotary_inc_a, rotary_inc_b};
        sync2_d = sync1_q;
    end

    assign push_s = sync2_q[2];
    assign ab     = sync2_q[1:0];

    // Quadrature decoder: next-state logic
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ab[1])      state_d = ST_A1;
                else if (ab[0]) state_d = ST_B1;
            end
            ST_A1: begin
                if (ab == 2'b11)      state_d = ST_AB_A;
                else if (ab == 2'b00) state_d = ST_IDLE;
            end
            ST_AB_A: begin
                if (ab == 2'b01)      state_d = ST_B_A;
                else if (ab == 2'b10) state_d = ST_A1;
                else if (ab == 2'b00) state_d = ST_IDLE;
            end
            ST_B_A: begin
                if (ab == 2'b11)      state_d = ST_AB_A;
                else if (ab == 2'b00) state_d = ST_IDLE;
            end
            ST_B1: begin
                if (ab == 2'b11)      state_d = ST_AB_B;
                else if (ab == 2'b00) state_d = ST_IDLE;
            end
            ST_AB_B: begin
                if (ab == 2'b10)      state_d = ST_A_B;
                else if (ab == 2'b01) state_d = ST_B1;
                else if (ab == 2'b00) state_d = ST_IDLE;
            end
            ST_A_B: begin
                if (ab == 2'b11)      state_d = ST_AB_B;
                else if (ab == 2'b00) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Quadrature decoder: detent outputs (a detent is the return to 00 from past mid-way)
    always_comb begin
        detent    = 1'b0;
        detent_up = 1'b0;
        if (ab == 2'b00) begin
            case (state_q)
                ST_AB_A, ST_B_A: detent = 1'b1;
                ST_AB_B, ST_A_B: begin
                    detent    = 1'b1;
                    detent_up = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Debounce: count saturates at DEB_DONE so a held button fires only once
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        press     = 1'b0;
        if (!push_s) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DEB_DONE) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
            press     = (deb_cnt_q == DEB_LAST);
        end
    end

    always_comb begin
        activity   = detent | press;
        idle_cnt_d = idle_cnt_q;
        sel_d      = sel_q;
        if (activity) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_DONE) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
        if (press) begin
            sel_d = (sel_q == SEL_CONTRAST) ? SEL_VOLUME : sel_q + 2'd1;
        end else if (!activity && idle_cnt_q == IDLE_LAST) begin
            sel_d = SEL_VOLUME;
        end
    end

    // The detent always lands on the pre-press selection.
    always_comb begin
        volume_d     = volume_q;
        brightness_d = brightness_q;
        contrast_d   = contrast_q;
        step_pulse_d = detent;
        step_up_d    = step_up_q;
        if (detent) begin
            step_up_d = detent_up;
            case (sel_q)
                SEL_VOLUME:     volume_d     = step_level(volume_q, detent_up);
                SEL_BRIGHTNESS: brightness_d = step_level(brightness_q, detent_up);
                SEL_CONTRAST:   contrast_d   = step_level(contrast_q, detent_up);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            state_q      <= ST_IDLE;
            deb_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            volume_q     <= VOLUME_RST;
            brightness_q <= BRIGHTNESS_RST;
            contrast_q   <= CONTRAST_RST;
            sel_q        <= SEL_VOLUME;
            step_pulse_q <= 1'b0;
            step_up_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            state_q      <= state_d;
            deb_cnt_q    <= deb_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            volume_q     <= volume_d;
            brightness_q <= brightness_d;
            contrast_q   <= contrast_d;
            sel_q        <= sel_d;
            step_pulse_q <= step_pulse_d;
            step_up_q    <= step_up_d;
        end
    end

    assign volume     = volume_q;
    assign brightness = brightness_q;
    assign contrast   = contrast_q;
    assign sel        = sel_q;
    assign step_pulse = step_pulse_q;
    assign step_up    = step_up_q;

endmodule

// File: tb/tb_rotary_settings_controller.sv
// Self-checking bench for rotary_settings_controller: detents are scoreboarded
// against a level model; selection, debounce, timeout and reset checked per task.
module tb_rotary_settings_controller;

    localparam int DEB = 16;
    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       rot_a;
    logic       rot_b;
    logic       push;
    logic [3:0] volume;
    logic [3:0] brightness;
    logic [3:0] contrast;
    logic [1:0] sel;
    logic       step_pulse;
    logic       step_up;

    always #5 clk = ~clk;

    rotary_settings_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rotary_inc_a(rot_a),
        .rotary_inc_b(rot_b),
        .rotary_push (push),
        .volume      (volume),
        .brightness  (brightness),
        .contrast    (contrast),
        .sel         (sel),
        .step_pulse  (step_pulse),
        .step_up     (step_up)
    );

    typedef struct packed {
        logic       up;
        logic [1:0] which;
        logic [3:0] level;
    } step_t;

    step_t      exp_q[$];
    logic [3:0] lvl_m[3];
    int         vectors     = 0;
    int         miscompares = 0;
    int         pulse_count = 0;
    int         sel_changes = 0;
    logic [1:0] sel_prev    = 2'd0;

    always @(negedge clk) begin
        if (step_pulse === 1'b1) pulse_count++;
        if (sel !== sel_prev) sel_changes++;
        sel_prev = sel;
    end

    function automatic logic [3:0] model_step(input logic [3:0] v, input logic up);
`ifdef LEVEL_WRAP_EN
        return up ? v + 4'd1 : v - 4'd1;
`else
        if (up) return (v == 4'hF) ? 4'hF : v + 4'd1;
        return (v == 4'h0) ? 4'h0 : v - 4'd1;
`endif
    endfunction

    function automatic logic [3:0] dut_level(input logic [1:0] w);
        case (w)
            2'd0:    return volume;
            2'd1:    return brightness;
            default: return contrast;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_step(input logic up, input logic [1:0] which);
        step_t e;
        lvl_m[which] = model_step(lvl_m[which], up);
        e.up    = up;
        e.which = which;
        e.level = lvl_m[which];
        exp_q.push_back(e);
    endtask

    // Drives the three non-idle quadrature phases, 4 cycles each; caller drives the final 00.
    task automatic drive_steps(input logic up);
        logic [1:0] seq [3];
        if (up) begin
            seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10;
        end else begin
            seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01;
        end
        for (int i = 0; i < 3; i++) begin
            {rot_a, rot_b} = seq[i];
            tick(4);
        end
    endtask

    task automatic wait_step(input string name);
        step_t e;
        bit    seen;
        seen = 1'b0;
        e = exp_q.pop_front();
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            seen = (step_pulse === 1'b1);
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s_pulse: step_pulse never rose within 12 cycles, want 1", name);
        end else begin
            vectors++;
            if (step_up !== e.up) begin
                miscompares++;
                $display("FAIL %s_dir: step_up=%b want %b", name, step_up, e.up);
            end
            vectors++;
            if (dut_level(e.which) !== e.level) begin
                miscompares++;
                $display("FAIL %s_level: level[%0d]=%h want %h", name, e.which,
                         dut_level(e.which), e.level);
            end
        end
        tick(1);
    endtask

    task automatic detent(input logic up, input logic [1:0] which, input string name);
        expect_step(up, which);
        drive_steps(up);
        {rot_a, rot_b} = 2'b00;
        wait_step(name);
        tick(4);
    endtask

    task automatic press_button(input int hold);
        push = 1'b1;
        tick(hold);
        push = 1'b0;
        tick(4);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rot_a = 1'b0;
        rot_b = 1'b0;
        push  = 1'b0;
        tick(3);
        reset = 1'b0;
        lvl_m[0] = 4'hE;
        lvl_m[1] = 4'h8;
        lvl_m[2] = 4'h8;
        vectors++;
        if (volume !== 4'hE) begin
            miscompares++; $display("FAIL reset_volume: got %h want e", volume);
        end
        vectors++;
        if (brightness !== 4'h8) begin
            miscompares++; $display("FAIL reset_brightness: got %h want 8", brightness);
        end
        vectors++;
        if (contrast !== 4'h8) begin
            miscompares++; $display("FAIL reset_contrast: got %h want 8", contrast);
        end
        vectors++;
        if (sel !== 2'd0) begin
            miscompares++; $display("FAIL reset_sel: got %0d want 0", sel);
        end
        vectors++;
        if (step_pulse !== 1'b0 || step_up !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_step: pulse=%b up=%b want 0 0", step_pulse, step_up);
        end
    endtask

    task automatic test_b_first;
        int p0;
        p0 = pulse_count;
        detent(1'b1, 2'd0, "b_first");
        vectors++;
        if (pulse_count - p0 !== 1) begin
            miscompares++; $display("FAIL b_first_count: %0d pulses want 1", pulse_count - p0);
        end
        vectors++;
        if (brightness !== lvl_m[1] || contrast !== lvl_m[2]) begin
            miscompares++;
            $display("FAIL b_first_hold: bright=%h contrast=%h want %h %h",
                     brightness, contrast, lvl_m[1], lvl_m[2]);
        end
    endtask

    task automatic test_push_a_first;
        int s0;
        s0 = sel_changes;
        press_button(20);
        vectors++;
        if (sel !== 2'd1) begin
            miscompares++; $display("FAIL push_sel: got %0d want 1", sel);
        end
        vectors++;
        if (sel_changes - s0 !== 1) begin
            miscompares++; $display("FAIL push_once: %0d sel changes want 1", sel_changes - s0);
        end
        detent(1'b0, 2'd1, "a_first");
        vectors++;
        if (volume !== lvl_m[0] || contrast !== lvl_m[2]) begin
            miscompares++;
            $display("FAIL a_first_hold: vol=%h contrast=%h want %h %h",
                     volume, contrast, lvl_m[0], lvl_m[2]);
        end
    endtask

    task automatic test_timeout;
        press_button(20);
        vectors++;
        if (sel !== 2'd2) begin
            miscompares++; $display("FAIL timeout_pre: sel=%0d want 2", sel);
        end
        tick(88);
        vectors++;
        if (sel !== 2'd2) begin
            miscompares++; $display("FAIL timeout_early: sel=%0d want 2", sel);
        end
        tick(10);
        vectors++;
        if (sel !== 2'd0) begin
            miscompares++; $display("FAIL timeout_return: sel=%0d want 0", sel);
        end
    endtask

    task automatic test_bounce;
        int s0;
        s0 = sel_changes;
        for (int i = 0; i < 10; i++) begin
            push = 1'b1;
            tick(5);
            push = 1'b0;
            tick(5);
        end
        tick(5);
        vectors++;
        if (sel !== 2'd0 || sel_changes - s0 !== 0) begin
            miscompares++;
            $display("FAIL bounce: sel=%0d changes=%0d want 0 0", sel, sel_changes - s0);
        end
    endtask

    task automatic test_detent_with_press;
        press_button(20);
        vectors++;
        if (sel !== 2'd1) begin
            miscompares++; $display("FAIL combo_pre: sel=%0d want 1", sel);
        end
        // Press lands 18 edges after the rise; the final 00 is driven 15 edges after it.
        push = 1'b1;
        tick(3);
        expect_step(1'b1, 2'd1);
        drive_steps(1'b1);
        {rot_a, rot_b} = 2'b00;
        wait_step("combo");
        vectors++;
        if (sel !== 2'd2) begin
            miscompares++; $display("FAIL combo_sel: sel=%0d want 2", sel);
        end
        push = 1'b0;
        tick(4);
        vectors++;
        if (volume !== lvl_m[0] || contrast !== lvl_m[2]) begin
            miscompares++;
            $display("FAIL combo_hold: vol=%h contrast=%h want %h %h",
                     volume, contrast, lvl_m[0], lvl_m[2]);
        end
    endtask

    task automatic test_saturate;
        press_button(20);
        vectors++;
        if (sel !== 2'd0) begin
            miscompares++; $display("FAIL sat_sel: sel=%0d want 0", sel);
        end
        detent(1'b1, 2'd0, "sat_up");
        detent(1'b0, 2'd0, "sat_down");
    endtask

    task automatic test_partial;
        int p0;
        p0 = pulse_count;
        {rot_a, rot_b} = 2'b10; tick(4);
        {rot_a, rot_b} = 2'b00; tick(8);
        {rot_a, rot_b} = 2'b01; tick(4);
        {rot_a, rot_b} = 2'b00; tick(8);
        vectors++;
        if (pulse_count - p0 !== 0) begin
            miscompares++; $display("FAIL partial: %0d pulses want 0", pulse_count - p0);
        end
        vectors++;
        if (volume !== lvl_m[0] || brightness !== lvl_m[1] || contrast !== lvl_m[2]) begin
            miscompares++;
            $display("FAIL partial_levels: %h %h %h want %h %h %h", volume, brightness,
                     contrast, lvl_m[0], lvl_m[1], lvl_m[2]);
        end
    endtask

    task automatic test_reset_mid;
        int p0;
        int s0;
        push = 1'b1;
        {rot_a, rot_b} = 2'b10; tick(4);
        {rot_a, rot_b} = 2'b11; tick(4);
        reset = 1'b1;
        {rot_a, rot_b} = 2'b00;
        tick(2);
        reset = 1'b0;
        p0 = pulse_count;
        s0 = sel_changes;
        lvl_m[0] = 4'hE;
        lvl_m[1] = 4'h8;
        lvl_m[2] = 4'h8;
        tick(10);
        push = 1'b0;
        tick(4);
        vectors++;
        if (pulse_count - p0 !== 0) begin
            miscompares++; $display("FAIL reset_mid_pulse: %0d pulses want 0", pulse_count - p0);
        end
        vectors++;
        if (volume !== 4'hE || brightness !== 4'h8 || contrast !== 4'h8) begin
            miscompares++;
            $display("FAIL reset_mid_levels: %h %h %h want e 8 8", volume, brightness, contrast);
        end
        vectors++;
        if (sel !== 2'd0 || sel_changes - s0 !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_press: sel=%0d changes=%0d want 0 0", sel, sel_changes - s0);
        end
    endtask

    initial begin
        test_reset();
        test_b_first();
        test_push_a_first();
        test_timeout();
        test_bounce();
        test_detent_with_press();
        test_saturate();
        test_partial();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
